data_memory_responder: RTL

- Responder end of the core's single-port memory command interface. The memory stage drives `mem_cmd_*`, `mem_addr`, `mem_wdata` and `mem_wmask` into this block; the block returns `mem_cmd_ready`, `mem_rdata` and `mem_rdata_valid`.
- Holds a word-organised RAM and accepts one command at a time.
- Reads complete after a fixed latency. Writes occupy the port for a configurable busy time.
- Used as the data memory in simulation and on FPGA.

---
 rtl/data_memory_responder_pkg.sv | 19 +
 rtl/data_memory_responder_if.sv | 23 ++
 rtl/data_memory_responder_ram_word.sv | 23 ++
 rtl/data_memory_responder.sv | 108 ++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the data-memory command interface: lane masks and responder state encodings.
package data_memory_responder_pkg;

  localparam logic [31:0] MASK_B = 32'h0000_00ff;
  localparam logic [31:0] MASK_H = 32'h0000_ffff;
  localparam logic [31:0] MASK_W = 32'hffff_ffff;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_BUSY = 2'd2
  } resp_state_t;

  // Byte offset within a word expressed as a bit-shift amount.
  function automatic logic [4:0] lane_shift(input logic [1:0] offset);
    return {offset, 3'b000};
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Memory command bus between the memory stage (master) and the data memory (slave).
interface data_memory_responder_if;
  // A command transfers on a rising edge where mem_cmd_start && mem_cmd_ready; start while
  // ready is low is dropped, not queued. mem_rdata_valid is a one-cycle pulse with no back-pressure.
  logic        mem_cmd_start;
  logic        mem_cmd_write;
  logic        mem_cmd_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;

  modport master (
    output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_cmd_ready, mem_rdata, mem_rdata_valid
  );

  modport slave (
    input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    output mem_cmd_ready, mem_rdata, mem_rdata_valid
  );
endinterface

// File: rtl/data_memory_responder_ram_word.sv
// Word-organised RAM with bit-masked synchronous write and asynchronous read; contents survive reset.
module data_ram_word #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [31:0]           wmask,
  output logic [31:0]           rdata
);

  logic [31:0] mem_array [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= (mem_array[addr] & ~wmask) | (wdata & wmask);
    end
  end

  assign rdata = mem_array[addr];

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one command at a time, fixed read latency, configurable write busy time.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_LOG2    = 12,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  data_memory_responder_if.slave   mem,
  output resp_state_t              dbg_state,
  output logic [3:0]               dbg_cnt
);

  localparam logic [3:0] RD_CNT_INIT = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_CNT_INIT = 4'((WRITE_LATENCY > 0) ? WRITE_LATENCY - 1 : 0);

  resp_state_t state;
  logic [3:0]  cnt;
  logic        cmd_ready;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic [31:0] rd_word;

  logic                  accept;
  logic [4:0]            shift;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           ram_rdata;
  logic                  unused_addr_hi;

  assign accept         = mem.mem_cmd_start & cmd_ready;
  assign shift          = lane_shift(mem.mem_addr[1:0]);
  assign word_idx       = mem.mem_addr[DEPTH_LOG2+1:2];
  assign unused_addr_hi = ^mem.mem_addr[31:DEPTH_LOG2+2];

  // Shifted mask/data are truncated to 32 bits, so a misaligned store never spills into the next word.
  data_ram_word #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (accept & mem.mem_cmd_write),
    .addr  (word_idx),
    .wdata (mem.mem_wdata << shift),
    .wmask (mem.mem_wmask << shift),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rd_word     <= '0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            if (!mem.mem_cmd_write) begin
              state     <= ST_READ_WAIT;
              cnt       <= RD_CNT_INIT;
              cmd_ready <= 1'b0;
              rd_word   <= ram_rdata >> shift;
            end else if (WRITE_LATENCY != 0) begin
              state     <= ST_WRITE_BUSY;
              cnt       <= WR_CNT_INIT;
              cmd_ready <= 1'b0;
            end
          end
        end
        // Ready rises together with the valid pulse so a new command can overlap the response.
        ST_READ_WAIT: begin
          if (cnt == 4'd0) begin
            rdata       <= rd_word;
            rdata_valid <= 1'b1;
            cmd_ready   <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WRITE_BUSY: begin
          if (cnt == 4'd0) begin
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_cmd_ready   = cmd_ready;
  assign mem.mem_rdata       = rdata;
  assign mem.mem_rdata_valid = rdata_valid;
  assign dbg_state           = state;
  assign dbg_cnt             = cnt;

endmodule
